// File: rtl/dram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dram_port_arbiter
// Purpose  : Shares one DRAM user interface among NUM_PORTS requesters.
//            Grants one command per cycle, bounds reads in flight with a
//            credit counter, and records the owner of each issued read in
//            an in-order tag FIFO so returned data is steered to its owner.
// Options  : DRAM_ARB_ROUND_ROBIN_EN -- defined: round-robin winner search
//            starting after the last winner; undefined: fixed priority,
//            lowest eligible port index wins.
// Revision : 1.0 - initial release
// ============================================================================
module dram_port_arbiter #(
   parameter int NUM_PORTS       = 4,
   parameter int ADDR_WIDTH      = 27,
   parameter int DATA_WIDTH      = 128,
   parameter int MASK_WIDTH      = 16,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_PORTS-1:0]               i_req,
   input  logic [NUM_PORTS-1:0]               i_wen,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]    i_addr,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]    i_data,
   input  logic [NUM_PORTS*MASK_WIDTH-1:0]    i_mask,
   output logic [NUM_PORTS-1:0]               o_gnt,
   output logic [DATA_WIDTH-1:0]              o_rdata,
   output logic [NUM_PORTS-1:0]               o_rvalid,
   output logic                               o_dram_ren,
   output logic                               o_dram_wen,
   output logic [ADDR_WIDTH-1:0]              o_dram_addr,
   output logic [DATA_WIDTH-1:0]              o_dram_data,
   output logic [MASK_WIDTH-1:0]              o_dram_mask,
   output logic                               o_dram_rbusy,
   input  logic                               i_dram_busy,
   input  logic [DATA_WIDTH-1:0]              i_dram_rdata,
   input  logic                               i_dram_rvalid,
   output logic [$clog2(MAX_OUTSTANDING):0]   o_outstanding,
   output logic                               o_err
);

   localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                state;
   state_t                state_next;
   logic [PW-1:0]         last;
   logic [PW-1:0]         winner;
   logic [PW-1:0]         cand;
   logic                  found;
   logic [NUM_PORTS-1:0]  eligible;
   logic                  credit_ok;
   logic                  issue;
   logic                  push;
   logic                  pop;
   logic                  tag_empty;
   logic [PW-1:0]         tag_mem [MAX_OUTSTANDING];
   logic [CW-1:0]         wr_ptr;
   logic [CW-1:0]         rd_ptr;

   // Writes never consume credit, so a credit-starved read cannot block them.
   assign credit_ok = (o_outstanding < CW'(MAX_OUTSTANDING));
   assign eligible  = i_req & (i_wen | {NUM_PORTS{credit_ok}});
   assign tag_empty = (wr_ptr == rd_ptr);
   assign issue     = (state == ST_RUN) && !i_dram_busy && found;
   assign push      = issue && !i_wen[winner];
   assign pop       = i_dram_rvalid && !tag_empty;

   // Winner search over eligible ports.
   always_comb begin
      winner = '0;
      cand   = '0;
      found  = 1'b0;
`ifdef DRAM_ARB_ROUND_ROBIN_EN
      for (int i = 1; i <= NUM_PORTS; i++) begin
         cand = PW'((int'(last) + i) % NUM_PORTS);
         if (!found && eligible[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
`else
      for (int i = 0; i < NUM_PORTS; i++) begin
         cand = PW'(i);
         if (!found && eligible[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
`endif
   end

`ifndef DRAM_ARB_ROUND_ROBIN_EN
   // Fixed priority keeps the last-winner register but never reads it.
   logic unused_last;
   assign unused_last = ^last;
`endif

   // Command fields always follow the current winner; strobes qualify them.
   assign o_dram_addr  = i_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
   assign o_dram_data  = i_data[winner*DATA_WIDTH +: DATA_WIDTH];
   assign o_dram_mask  = i_mask[winner*MASK_WIDTH +: MASK_WIDTH];
   assign o_dram_rbusy = 1'b0;

   // State register: stay in INIT until DRAM calibration finishes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_INIT;
      else     state <= state_next;
   end

   // Next-state and grant/command strobes; nothing issues in INIT.
   always_comb begin
      state_next = state;
      o_gnt      = '0;
      o_dram_ren = 1'b0;
      o_dram_wen = 1'b0;
      case (state)
         ST_INIT: begin
            if (!i_dram_busy) state_next = ST_RUN;
         end
         ST_RUN: begin
            if (issue) begin
               o_gnt[winner] = 1'b1;
               o_dram_wen    = i_wen[winner];
               o_dram_ren    = !i_wen[winner];
            end
         end
         default: state_next = ST_INIT;
      endcase
   end

   // Last winner; reset to the top port so port 0 is searched first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        last <= PW'(NUM_PORTS - 1);
      else if (issue) last <= winner;
   end

   // Tag storage holds the owner of every read in issue order.
   always_ff @(posedge clk) begin
      if (push) tag_mem[wr_ptr[CW-2:0]] <= winner;
   end

   // Tag pointers, credit count, return steering and sticky error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         o_outstanding <= '0;
         o_rvalid      <= '0;
         o_rdata       <= '0;
         o_err         <= 1'b0;
      end else begin
         o_rvalid <= '0;
         if (push) wr_ptr <= wr_ptr + CW'(1);
         if (pop) begin
            rd_ptr                           <= rd_ptr + CW'(1);
            o_rvalid[tag_mem[rd_ptr[CW-2:0]]] <= 1'b1;
            o_rdata                          <= i_dram_rdata;
         end
         o_outstanding <= o_outstanding + CW'(push) - CW'(pop);
         if (i_dram_rvalid && tag_empty) o_err <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dram_port_arbiter
// Purpose  : Self-checking bench for dram_port_arbiter. Directed scenarios
//            followed by random traffic, compared every cycle against a
//            queue-based reference model. Honours DRAM_ARB_ROUND_ROBIN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dram_port_arbiter;

   localparam int NP = 4;
   localparam int AW = 27;
   localparam int DW = 128;
   localparam int MW = 16;
   localparam int MO = 8;
   localparam int CW = $clog2(MO) + 1;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [NP-1:0]     i_req = '0;
   logic [NP-1:0]     i_wen = '0;
   logic [NP*AW-1:0]  i_addr = '0;
   logic [NP*DW-1:0]  i_data = '0;
   logic [NP*MW-1:0]  i_mask = '0;
   logic [NP-1:0]     o_gnt;
   logic [DW-1:0]     o_rdata;
   logic [NP-1:0]     o_rvalid;
   logic              o_dram_ren;
   logic              o_dram_wen;
   logic [AW-1:0]     o_dram_addr;
   logic [DW-1:0]     o_dram_data;
   logic [MW-1:0]     o_dram_mask;
   logic              o_dram_rbusy;
   logic              i_dram_busy = 1'b1;
   logic [DW-1:0]     i_dram_rdata = '0;
   logic              i_dram_rvalid = 1'b0;
   logic [CW-1:0]     o_outstanding;
   logic              o_err;

   dram_port_arbiter #(
      .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .MASK_WIDTH(MW), .MAX_OUTSTANDING(MO)
   ) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_wen(i_wen), .i_addr(i_addr), .i_data(i_data), .i_mask(i_mask),
      .o_gnt(o_gnt), .o_rdata(o_rdata), .o_rvalid(o_rvalid),
      .o_dram_ren(o_dram_ren), .o_dram_wen(o_dram_wen), .o_dram_addr(o_dram_addr),
      .o_dram_data(o_dram_data), .o_dram_mask(o_dram_mask), .o_dram_rbusy(o_dram_rbusy),
      .i_dram_busy(i_dram_busy), .i_dram_rdata(i_dram_rdata), .i_dram_rvalid(i_dram_rvalid),
      .o_outstanding(o_outstanding), .o_err(o_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Pending commands held by each requester until granted.
   bit            pend [NP];
   bit            pw   [NP];
   logic [AW-1:0] pa   [NP];
   logic [DW-1:0] pd   [NP];
   logic [MW-1:0] pm   [NP];

   // Reference model state.
   bit            run_m;
   int            last_m;
   int            tagq [$];
   bit            err_m;
   int            exp_rv;
   logic [DW-1:0] exp_rdata;
   int            ghist [$];

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic set_cmd(input int k, input bit wen);
      pend[k] = 1'b1;
      pw[k]   = wen;
      pa[k]   = AW'($urandom);
      pd[k]   = rnd128();
      pm[k]   = MW'($urandom);
   endtask

   task automatic drive();
      for (int k = 0; k < NP; k++) begin
         i_req[k]            = pend[k];
         i_wen[k]            = pw[k];
         i_addr[k*AW +: AW]  = pa[k];
         i_data[k*DW +: DW]  = pd[k];
         i_mask[k*MW +: MW]  = pm[k];
      end
   endtask

   // One clock cycle: drive at negedge, check mid-cycle, advance model.
   task automatic cycle(input bit busy, input bit rv, input logic [DW-1:0] rd);
      int w;
      int nxt_rv;
      logic [NP-1:0] eg;
      i_dram_busy   = busy;
      i_dram_rvalid = rv;
      i_dram_rdata  = rd;
      drive();
      #2;
      w = -1;
      if (run_m && !busy) begin
`ifdef DRAM_ARB_ROUND_ROBIN_EN
         for (int i = 1; i <= NP; i++) begin
            int k = (last_m + i) % NP;
            if (w < 0 && pend[k] && (pw[k] || tagq.size() < MO)) w = k;
         end
`else
         for (int k = 0; k < NP; k++)
            if (w < 0 && pend[k] && (pw[k] || tagq.size() < MO)) w = k;
`endif
      end
      eg = '0;
      if (w >= 0) eg[w] = 1'b1;
      chk("gnt", DW'(o_gnt), DW'(eg));
      chk("ren", DW'(o_dram_ren), DW'(w >= 0 && !pw[w]));
      chk("wen", DW'(o_dram_wen), DW'(w >= 0 && pw[w]));
      chk("rbusy", DW'(o_dram_rbusy), '0);
      if (w >= 0) begin
         chk("addr", DW'(o_dram_addr), DW'(pa[w]));
         chk("wdata", o_dram_data, pd[w]);
         chk("mask", DW'(o_dram_mask), DW'(pm[w]));
      end
      chk("outstanding", DW'(o_outstanding), DW'(tagq.size()));
      chk("err", DW'(o_err), DW'(err_m));
      eg = '0;
      if (exp_rv >= 0) eg[exp_rv] = 1'b1;
      chk("rvalid", DW'(o_rvalid), DW'(eg));
      chk("rdata", o_rdata, exp_rdata);
      // Model update: return pops the oldest tag, issue appends a new one.
      nxt_rv = -1;
      if (rv) begin
         if (tagq.size() > 0) begin
            nxt_rv    = tagq.pop_front();
            exp_rdata = rd;
         end else begin
            err_m = 1'b1;
         end
      end
      if (w >= 0) begin
         last_m = w;
         if (!pw[w]) tagq.push_back(w);
         pend[w] = 1'b0;
         ghist.push_back(w);
      end
      if (!run_m && !busy) run_m = 1'b1;
      @(posedge clk);
      @(negedge clk);
      exp_rv = nxt_rv;
   endtask

   task automatic do_reset();
      @(negedge clk);
      for (int k = 0; k < NP; k++) pend[k] = 1'b0;
      drive();
      i_dram_busy   = 1'b1;
      i_dram_rvalid = 1'b0;
      rst = 1'b1;
      #2;
      chk("rst_gnt", DW'(o_gnt), '0);
      chk("rst_outstanding", DW'(o_outstanding), '0);
      chk("rst_err", DW'(o_err), '0);
      chk("rst_rvalid", DW'(o_rvalid), '0);
      chk("rst_rdata", o_rdata, '0);
      @(negedge clk);
      rst = 1'b0;
      run_m     = 1'b0;
      last_m    = NP - 1;
      tagq.delete();
      err_m     = 1'b0;
      exp_rv    = -1;
      exp_rdata = '0;
   endtask

   task automatic drain();
      for (int n = 0; n < 2 * MO && tagq.size() > 0; n++) cycle(1'b0, 1'b1, rnd128());
      chk("drained", DW'(o_outstanding), '0);
   endtask

   task automatic flush();
      for (int n = 0; n < 4 * NP; n++) begin
         bit any = 1'b0;
         for (int k = 0; k < NP; k++) any |= pend[k];
         if (any) cycle(1'b0, 1'b0, '0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int cnt [NP];
      int req_n;
      logic [NP-1:0] steer_exp [4];
      steer_exp[0] = 4'b0100; steer_exp[1] = 4'b0001;
      steer_exp[2] = 4'b1000; steer_exp[3] = 4'b0100;

      do_reset();

      // Calibration: busy held with all ports requesting gives no grants.
      for (int k = 0; k < NP; k++) set_cmd(k, 1'b1);
      repeat (20) cycle(1'b1, 1'b0, '0);
      chk("calib_no_gnt", DW'(ghist.size()), '0);
      for (int n = 0; n < 4 && ghist.size() == 0; n++) cycle(1'b0, 1'b0, '0);
      chk("first_gnt_port", DW'(ghist.size() > 0 ? ghist[0] : -1), '0);

      // Continuous writes from every port.
      base = ghist.size();
      for (int n = 0; n < 100; n++) begin
         for (int k = 0; k < NP; k++) if (!pend[k]) set_cmd(k, 1'b1);
         cycle(1'b0, 1'b0, '0);
      end
`ifdef DRAM_ARB_ROUND_ROBIN_EN
      for (int k = 0; k < NP; k++) cnt[k] = 0;
      for (int i = base; i < ghist.size(); i++) cnt[ghist[i]]++;
      for (int k = 0; k < NP; k++) chk("rr_share", DW'(cnt[k]), DW'(25));
`endif
      flush();

      // Credit limit: nine reads from port 1 with no returns.
      req_n = 0;
      for (int n = 0; n < 12; n++) begin
         if (!pend[1] && req_n < 9) begin set_cmd(1, 1'b0); req_n++; end
         cycle(1'b0, 1'b0, '0);
      end
      chk("credit_full", DW'(o_outstanding), DW'(MO));
      chk("ninth_held_req", DW'(i_req[1]), DW'(1));
      set_cmd(2, 1'b1);
      cycle(1'b0, 1'b0, '0);
      chk("write_past_credit", DW'(pend[2]), '0);
      cycle(1'b0, 1'b1, rnd128());
      cycle(1'b0, 1'b0, '0);
      chk("ninth_granted", DW'(o_outstanding), DW'(MO));
      drain();

      // Return steering: reads issued by ports 2,0,3,2.
      set_cmd(2, 1'b0); cycle(1'b0, 1'b0, '0);
      set_cmd(0, 1'b0); cycle(1'b0, 1'b0, '0);
      set_cmd(3, 1'b0); cycle(1'b0, 1'b0, '0);
      set_cmd(2, 1'b0); cycle(1'b0, 1'b0, '0);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b1, rnd128());
         chk("steer_seq", DW'(o_rvalid), DW'(steer_exp[i]));
      end
      cycle(1'b0, 1'b0, '0);

      // Simultaneous issue and return at three in flight.
      for (int i = 0; i < 3; i++) begin set_cmd(0, 1'b0); cycle(1'b0, 1'b0, '0); end
      set_cmd(1, 1'b0);
      cycle(1'b0, 1'b1, rnd128());
      chk("issue_and_return", DW'(o_outstanding), DW'(3));
      drain();

      // Stray return with nothing in flight.
      cycle(1'b0, 1'b1, rnd128());
      chk("stray_err", DW'(o_err), DW'(1));
      chk("stray_no_rvalid", DW'(o_rvalid), '0);
      cycle(1'b0, 1'b0, '0);
      chk("err_sticky", DW'(o_err), DW'(1));

      // Reset clears error and credits.
      do_reset();
      chk("post_rst_err", DW'(o_err), '0);
      chk("post_rst_count", DW'(o_outstanding), '0);

      // Random traffic.
      for (int n = 0; n < 1500; n++) begin
         for (int k = 0; k < NP; k++)
            if (!pend[k] && $urandom_range(0, 2) == 0) set_cmd(k, 1'($urandom_range(0, 1)));
         cycle(1'($urandom_range(0, 4) == 0),
               1'(tagq.size() > 0 && $urandom_range(0, 2) == 0), rnd128());
      end
      flush();
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
